// File: rtl/axis_accel_seq.sv
// Job sequencer for the enc/dec AXI-stream accelerator selector: drives mode select and ap_start,
// counts output beats and returns a status record. Optional watchdog: AXIS_ACCEL_SEQ_TIMEOUT_EN.
module axis_accel_seq #(
    parameter int BEAT_CNT_W = 16,
    parameter int TIMEOUT_W  = 24
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_use_enc,
    input  logic [BEAT_CNT_W-1:0] cmd_beats,
    output logic                  USE_ENC,
    output logic                  ap_start,
    input  logic                  ap_ready,
    input  logic                  ap_done,
    input  logic                  ap_idle,
    input  logic                  out_V_TVALID,
    input  logic                  out_V_TREADY,
    output logic                  sts_valid,
    input  logic                  sts_ready,
    output logic                  sts_use_enc,
    output logic [BEAT_CNT_W-1:0] sts_beats,
    output logic [1:0]            sts_err,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_START,
        S_RUN,
        S_REPORT
    } state_t;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISMATCH = 2'b01;
    localparam logic [1:0] ERR_ZERO     = 2'b10;

    state_t                state_q, state_d;
    logic                  use_enc_q, use_enc_d;
    logic                  ap_start_q, ap_start_d;
    logic                  sts_valid_q, sts_valid_d;
    logic                  sts_use_enc_q, sts_use_enc_d;
    logic [BEAT_CNT_W-1:0] sts_beats_q, sts_beats_d;
    logic [1:0]            sts_err_q, sts_err_d;
    logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [BEAT_CNT_W-1:0] exp_beats_q, exp_beats_d;
    logic                  busy_q;
    logic                  in_job;
    logic                  beat;

`ifdef AXIS_ACCEL_SEQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0]  wdog_q, wdog_d;
`endif

    assign in_job = (state_q == S_START) || (state_q == S_RUN);
    assign beat   = in_job && out_V_TVALID && out_V_TREADY;

    always_comb begin
        state_d       = state_q;
        use_enc_d     = use_enc_q;
        ap_start_d    = ap_start_q;
        sts_valid_d   = sts_valid_q;
        sts_use_enc_d = sts_use_enc_q;
        sts_beats_d   = sts_beats_q;
        sts_err_d     = sts_err_q;
        exp_beats_d   = exp_beats_q;
        beat_cnt_d    = beat_cnt_q;

        if (beat && (beat_cnt_q != '1)) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    use_enc_d   = cmd_use_enc;
                    exp_beats_d = cmd_beats;
                    beat_cnt_d  = '0;
                    if (cmd_beats == '0) begin
                        state_d       = S_REPORT;
                        sts_valid_d   = 1'b1;
                        sts_use_enc_d = cmd_use_enc;
                        sts_beats_d   = '0;
                        sts_err_d     = ERR_ZERO;
                    end else begin
                        state_d = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (ap_idle) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // First START cycle raises ap_start; ap_ready only counts once it is high.
                if (!ap_start_q) begin
                    ap_start_d = 1'b1;
                end else if (ap_ready) begin
                    ap_start_d = 1'b0;
                    state_d    = S_RUN;
                    if (ap_done) begin
                        state_d       = S_REPORT;
                        sts_valid_d   = 1'b1;
                        sts_use_enc_d = use_enc_q;
                        sts_beats_d   = beat_cnt_d;
                        sts_err_d     = (beat_cnt_d != exp_beats_q) ? ERR_MISMATCH : ERR_OK;
                    end
                end
            end
            S_RUN: begin
                if (ap_done) begin
                    state_d       = S_REPORT;
                    sts_valid_d   = 1'b1;
                    sts_use_enc_d = use_enc_q;
                    sts_beats_d   = beat_cnt_d;
                    sts_err_d     = (beat_cnt_d != exp_beats_q) ? ERR_MISMATCH : ERR_OK;
                end
            end
            S_REPORT: begin
                if (sts_ready) begin
                    sts_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef AXIS_ACCEL_SEQ_TIMEOUT_EN
        wdog_d = wdog_q;
        if (state_q == S_WAIT_IDLE) begin
            wdog_d = '0;
        end else if (in_job) begin
            wdog_d = beat ? '0 : wdog_q + 1'b1;
        end
        // Timeout overrides any same-cycle completion decided above.
        if (in_job && (wdog_d == '1)) begin
            ap_start_d    = 1'b0;
            state_d       = S_REPORT;
            sts_valid_d   = 1'b1;
            sts_use_enc_d = use_enc_q;
            sts_beats_d   = beat_cnt_d;
            sts_err_d     = 2'b11;
        end
`endif
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q       <= S_IDLE;
            use_enc_q     <= 1'b0;
            ap_start_q    <= 1'b0;
            sts_valid_q   <= 1'b0;
            sts_use_enc_q <= 1'b0;
            sts_beats_q   <= '0;
            sts_err_q     <= ERR_OK;
            beat_cnt_q    <= '0;
            exp_beats_q   <= '0;
            busy_q        <= 1'b0;
`ifdef AXIS_ACCEL_SEQ_TIMEOUT_EN
            wdog_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            use_enc_q     <= use_enc_d;
            ap_start_q    <= ap_start_d;
            sts_valid_q   <= sts_valid_d;
            sts_use_enc_q <= sts_use_enc_d;
            sts_beats_q   <= sts_beats_d;
            sts_err_q     <= sts_err_d;
            beat_cnt_q    <= beat_cnt_d;
            exp_beats_q   <= exp_beats_d;
            busy_q        <= (state_d != S_IDLE);
`ifdef AXIS_ACCEL_SEQ_TIMEOUT_EN
            wdog_q        <= wdog_d;
`endif
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign USE_ENC     = use_enc_q;
    assign ap_start    = ap_start_q;
    assign sts_valid   = sts_valid_q;
    assign sts_use_enc = sts_use_enc_q;
    assign sts_beats   = sts_beats_q;
    assign sts_err     = sts_err_q;
    assign busy        = busy_q;

endmodule
